// File: rtl/image_pkg.sv
// Shared types and constants for the image writer: FSM state, coordinate type, frame size.
package image_pkg;

   localparam int unsigned COORD_W_DEF  = 4;
   localparam int unsigned FRAME_PIXELS = 256;

   typedef logic [COORD_W_DEF-1:0] coord_t;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } state_e;

endpackage

// File: rtl/image_writer_if.sv
// Upstream pixel stream plus frame-memory write port of the image writer.
// Optional checksum signal present when IMAGE_WRITER_CHKSUM_EN is defined.
interface image_writer_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COORD_W = 4
);
   logic               start;
   logic               clear;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               in_ready;
   logic               wr_en;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic [DATA_W-1:0]  wr_data;
   logic               busy;
   logic               frame_done;
`ifdef IMAGE_WRITER_CHKSUM_EN
   logic [DATA_W-1:0]  checksum;

   modport master (
      output start, clear, in_valid, in_data,
      input  in_ready, wr_en, wr_x, wr_y, wr_data, busy, frame_done, checksum
   );

   modport slave (
      input  start, clear, in_valid, in_data,
      output in_ready, wr_en, wr_x, wr_y, wr_data, busy, frame_done, checksum
   );
`else
   modport master (
      output start, clear, in_valid, in_data,
      input  in_ready, wr_en, wr_x, wr_y, wr_data, busy, frame_done
   );

   modport slave (
      input  start, clear, in_valid, in_data,
      output in_ready, wr_en, wr_x, wr_y, wr_data, busy, frame_done
   );
`endif

endinterface

// File: rtl/pixel_coord_counter.sv
// Row-major x/y pixel counter with enable, synchronous clear and last-pixel flag.
module pixel_coord_counter #(
   parameter int unsigned COORD_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);

   logic [COORD_W-1:0] x_q, y_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (clr) begin
         x_q <= '0;
         y_q <= '0;
      end else if (en) begin
         x_q <= x_q + COORD_W'(1);
         // Both wrap together after the last pixel, so the next frame starts at (0,0).
         if (x_q == '1) begin
            y_q <= y_q + COORD_W'(1);
         end
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == '1) && (y_q == '1);

endmodule

// File: rtl/image_writer.sv
// Loads one frame of pixels from a valid/ready stream into frame memory in row-major order.
// Define IMAGE_WRITER_CHKSUM_EN to add a running XOR checksum of accepted pixels.
module image_writer
   import image_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COORD_W = 4
) (
   input logic          clk,
   input logic          rst,
   image_writer_if.slave bus
);

   state_e             state_q, state_d;
   logic               accept;
   logic               last;
   logic [COORD_W-1:0] cur_x, cur_y;

   logic               wr_en_q;
   logic [COORD_W-1:0] wr_x_q, wr_y_q;
   logic [DATA_W-1:0]  wr_data_q;

   // A beat coinciding with clear is dropped.
   assign accept = (state_q == StLoad) && bus.in_valid && !bus.clear;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.start) state_d = StLoad;
         StLoad:  if (accept && last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.clear) state_d = StIdle;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   pixel_coord_counter #(
      .COORD_W (COORD_W)
   ) u_coord (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .clr  (bus.clear),
      .x    (cur_x),
      .y    (cur_y),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_x_q    <= '0;
         wr_y_q    <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= accept;
         if (accept) begin
            wr_x_q    <= cur_x;
            wr_y_q    <= cur_y;
            wr_data_q <= bus.in_data;
         end
      end
   end

   assign bus.in_ready   = (state_q == StLoad);
   assign bus.busy       = (state_q != StIdle);
   // DONE lasts exactly one cycle, which is the cycle of the final write.
   assign bus.frame_done = (state_q == StDone);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_x       = wr_x_q;
   assign bus.wr_y       = wr_y_q;
   assign bus.wr_data    = wr_data_q;

`ifdef IMAGE_WRITER_CHKSUM_EN
   logic [DATA_W-1:0] chk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q <= '0;
      end else if (bus.clear) begin
         chk_q <= '0;
      end else if ((state_q == StIdle) && bus.start) begin
         chk_q <= '0;
      end else if (accept) begin
         chk_q <= chk_q ^ bus.in_data;
      end
   end

   assign bus.checksum = chk_q;
`endif

endmodule

// File: tb/tb_image_writer.sv
// Self-checking bench for image_writer: behavioural model feeding a write scoreboard,
// a table of per-cycle vectors, and directed frame/clear/reset sequences.
module tb_image_writer;
   import image_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;

   logic clk;
   logic rst;

   image_writer_if #(.DATA_W(DW), .COORD_W(CW)) bus ();

   image_writer #(
      .DATA_W  (DW),
      .COORD_W (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [DW-1:0] d;
      logic          last;
   } wr_t;

   typedef struct {
      logic          start;
      logic          clear;
      logic          valid;
      logic [DW-1:0] data;
      logic          exp_ready;
      logic          exp_busy;
      logic          exp_wr;
   } vec_t;

   wr_t    sb[$];
   wr_t    mon_w;
   state_e m_state;
   coord_t m_x, m_y;
   int     exp_frames;
   int     got_frames;
   int     errors;
   int     checks;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_state = StIdle;
      m_x     = '0;
      m_y     = '0;
   endtask

   task automatic model_edge(input logic s, input logic c, input logic v, input logic [DW-1:0] d);
      wr_t w;
      if (c) begin
         model_reset();
      end else begin
         case (m_state)
            StIdle: if (s) m_state = StLoad;
            StLoad: if (v) begin
               w.x    = m_x;
               w.y    = m_y;
               w.d    = d;
               w.last = (m_x == 4'hF) && (m_y == 4'hF);
               sb.push_back(w);
               if (w.last) begin
                  m_state = StDone;
                  exp_frames++;
               end
               m_x = m_x + 1'b1;
               if (m_x == '0) m_y = m_y + 1'b1;
            end
            default: m_state = StIdle;
         endcase
      end
   endtask

   // Inputs change at the falling edge; outputs are checked at the next falling edge.
   task automatic step(input logic s, input logic c, input logic v, input logic [DW-1:0] d);
      bus.start    = s;
      bus.clear    = c;
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      model_edge(s, c, v, d);
      @(negedge clk);
      check("in_ready", bus.in_ready, m_state == StLoad);
      check("busy", bus.busy, m_state != StIdle);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_wr_en"}, bus.wr_en, 0);
      check({tag, "_wr_x"}, bus.wr_x, 0);
      check({tag, "_wr_y"}, bus.wr_y, 0);
      check({tag, "_wr_data"}, bus.wr_data, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_frame_done"}, bus.frame_done, 0);
   endtask

   // Write monitor: every wr_en must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got x=%0d y=%0d data=%0h, want no write (t=%0t)",
                        bus.wr_x, bus.wr_y, bus.wr_data, $time);
            end else begin
               mon_w = sb.pop_front();
               check("wr_x", bus.wr_x, mon_w.x);
               check("wr_y", bus.wr_y, mon_w.y);
               check("wr_data", bus.wr_data, mon_w.d);
               check("frame_done_with_write", bus.frame_done, mon_w.last);
            end
         end else begin
            check("frame_done_no_write", bus.frame_done, 0);
         end
         if (bus.frame_done) got_frames++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want bench completion");
      $fatal(1, "watchdog expired");
   end

   vec_t tbl[7];
   int   n;

   initial begin
`ifdef IMAGE_WRITER_CHKSUM_EN
      logic [DW-1:0] exp_chk;
`endif
      errors       = 0;
      checks       = 0;
      exp_frames   = 0;
      got_frames   = 0;
      bus.start    = 1'b0;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      model_reset();
      rst = 1'b1;

      tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h00AB, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Per-cycle vectors: idle beat ignored, start, write, gap, start-while-busy, clear.
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].start, tbl[i].clear, tbl[i].valid, tbl[i].data);
         check($sformatf("tbl%0d_ready", i), bus.in_ready, tbl[i].exp_ready);
         check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].exp_busy);
         check($sformatf("tbl%0d_wr_en", i), bus.wr_en, tbl[i].exp_wr);
      end

      // Full back-to-back frame, data = pixel index.
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 1'b1, DW'(i));
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);
      check("frame1_count", got_frames, 1);
      check("frame1_drained", sb.size(), 0);

      // Alternating valid, with a start pulse mid-frame that must be ignored.
      step(1'b1, 1'b0, 1'b0, '0);
      n = 0;
      for (int i = 0; n < 256; i++) begin
         if (i % 2 == 0) begin
            step(i == 100, 1'b0, 1'b1, DW'(n + 16'h100));
            n++;
         end else begin
            step(i == 101, 1'b0, 1'b0, '0);
         end
      end
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);
      check("frame2_count", got_frames, 2);
      check("frame2_drained", sb.size(), 0);

      // Clear after 37 beats; the beat alongside clear is discarded.
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 37; i++) step(1'b0, 1'b0, 1'b1, DW'(i + 16'h200));
      step(1'b0, 1'b1, 1'b1, 16'h02FF);
      check("clear_wr_en", bus.wr_en, 0);
      repeat (2) step(1'b0, 1'b0, 1'b1, 16'h02EE);
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, DW'(i + 16'h300));
      step(1'b0, 1'b1, 1'b0, '0);
      check("clear_frames", got_frames, exp_frames);

      // Asynchronous reset between clock edges during LOAD.
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'(i + 16'h400));
      check("pre_reset_wr_en", bus.wr_en, 1);
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      model_reset();
      check("reset_drained", sb.size(), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step(1'b0, 1'b0, 1'b1, 16'h0055);
      check("reset_no_frame", got_frames, 2);

`ifdef IMAGE_WRITER_CHKSUM_EN
      exp_chk = '0;
      step(1'b1, 1'b0, 1'b0, '0);
      check("chk_after_start", bus.checksum, 0);
      for (int i = 1; i <= 256; i++) begin
         step(1'b0, 1'b0, 1'b1, DW'(i));
         exp_chk = exp_chk ^ DW'(i);
      end
      check("chk_frame_done", bus.frame_done, 1);
      check("chk_at_done", bus.checksum, exp_chk);
      repeat (3) step(1'b0, 1'b0, 1'b0, '0);
      check("chk_held", bus.checksum, exp_chk);
      step(1'b1, 1'b0, 1'b0, '0);
      check("chk_cleared_by_start", bus.checksum, 0);
      step(1'b0, 1'b1, 1'b0, '0);
`endif

      repeat (2) step(1'b0, 1'b0, 1'b0, '0);
      check("final_drained", sb.size(), 0);
      check("final_frames", got_frames, exp_frames);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
